shared_addsub_rr: RTL and testbench

//  Time-multiplexed add/subtract unit: one WIDTH-bit adder shared by CHANNELS

---
 rtl/shared_addsub_rr_if.sv | 29 ++
 rtl/shared_addsub_rr.sv | 83 ++++++++
 tb/tb_shared_addsub_rr.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/shared_addsub_rr_if.sv
// Request/result bus for the shared add/subtract unit: per-channel request
// lanes into the arbiter and a single registered result channel out.
interface shared_addsub_rr_if #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CH_W     = 2
);
  logic [CHANNELS-1:0]       req_valid;
  logic [CHANNELS-1:0]       req_ready;
  logic [CHANNELS*WIDTH-1:0] req_a;
  logic [CHANNELS*WIDTH-1:0] req_b;
  logic [CHANNELS-1:0]       req_m;
  logic                      res_valid;
  logic                      res_ready;
  logic [WIDTH-1:0]          res_data;
  logic                      res_cout;
  logic [CH_W-1:0]           res_ch;
  logic                      res_m;

  modport master (
    output req_valid, req_a, req_b, req_m, res_ready,
    input  req_ready, res_valid, res_data, res_cout, res_ch, res_m
  );

  modport slave (
    input  req_valid, req_a, req_b, req_m, res_ready,
    output req_ready, res_valid, res_data, res_cout, res_ch, res_m
  );
endinterface

// File: rtl/shared_addsub_rr.sv
// One WIDTH-bit adder/subtractor time-shared by CHANNELS requesters under a
// round-robin arbiter, feeding a single-entry result buffer with backpressure.
module shared_addsub_rr #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CH_W     = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  shared_addsub_rr_if.slave  bus
);

  logic [CH_W-1:0]     ptr;
  logic [CH_W-1:0]     grant_idx;
  logic                grant_any;
  logic                free;
  logic [CHANNELS-1:0] grant_onehot;
  logic [WIDTH-1:0]    op_a;
  logic [WIDTH-1:0]    op_b;
  logic                op_m;
  logic [WIDTH:0]      op_res;
  logic [CH_W-1:0]     ptr_next;
  int unsigned         idx;

  // The buffer may refill in the same cycle it is being drained.
  assign free = !bus.res_valid || bus.res_ready;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      idx = (32'(ptr) + k) % CHANNELS;
      if (!grant_any && bus.req_valid[CH_W'(idx)]) begin
        grant_any = 1'b1;
        grant_idx = CH_W'(idx);
      end
    end
    if (!(free && rst_n)) begin
      grant_any = 1'b0;
    end
  end

  always_comb begin
    grant_onehot = '0;
    if (grant_any) begin
      grant_onehot[grant_idx] = 1'b1;
    end
  end

  assign bus.req_ready = grant_onehot;

  assign op_a = bus.req_a[grant_idx*WIDTH +: WIDTH];
  assign op_b = bus.req_b[grant_idx*WIDTH +: WIDTH];
  assign op_m = bus.req_m[grant_idx];

  // Top bit is carry for add and borrow (a<b) for subtract.
  assign op_res = op_m ? ({1'b0, op_a} - {1'b0, op_b})
                       : ({1'b0, op_a} + {1'b0, op_b});

  assign ptr_next = (grant_idx == CH_W'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_cout  <= 1'b0;
      bus.res_ch    <= '0;
      bus.res_m     <= 1'b0;
      ptr           <= '0;
    end else if (grant_any) begin
      bus.res_valid <= 1'b1;
      bus.res_data  <= op_res[WIDTH-1:0];
      bus.res_cout  <= op_res[WIDTH];
      bus.res_ch    <= grant_idx;
      bus.res_m     <= op_m;
      ptr           <= ptr_next;
    end else if (bus.res_valid && bus.res_ready) begin
      bus.res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shared_addsub_rr.sv
// Self-checking bench for shared_addsub_rr: directed scenarios plus a
// randomized run against an arithmetic round-robin reference model.
module tb_shared_addsub_rr;
  localparam int WIDTH = 4;
  localparam int CHANNELS = 4;
  localparam int CH_W = 2;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  // Reference model state
  int m_ptr;
  int m_valid;
  int m_data;
  int m_cout;
  int m_ch;
  int m_m;

  shared_addsub_rr_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .CH_W(CH_W)) bus ();

  shared_addsub_rr #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .CH_W(CH_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int exp_grant();
    int i;
    if (rst_n !== 1'b1) return -1;
    if (m_valid != 0 && bus.res_ready !== 1'b1) return -1;
    for (int k = 0; k < CHANNELS; k++) begin
      i = (m_ptr + k) % CHANNELS;
      if (bus.req_valid[i] === 1'b1) return i;
    end
    return -1;
  endfunction

  function automatic logic [CHANNELS-1:0] exp_ready();
    logic [CHANNELS-1:0] r;
    int g;
    r = '0;
    g = exp_grant();
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_data = 0; m_cout = 0; m_ch = 0; m_m = 0;
  endtask

  // Advance one clock edge and update the model; outputs are then sampled 1ns later.
  task automatic tick();
    int g, a, b, m;
    g = exp_grant();
    @(posedge clk);
    if (g >= 0) begin
      a = int'(bus.req_a[g*WIDTH +: WIDTH]);
      b = int'(bus.req_b[g*WIDTH +: WIDTH]);
      m = int'(bus.req_m[g]);
      if (m == 0) begin
        m_data = (a + b) % 16;
        m_cout = (a + b >= 16) ? 1 : 0;
      end else begin
        m_data = (a - b + 16) % 16;
        m_cout = (a < b) ? 1 : 0;
      end
      m_valid = 1; m_ch = g; m_m = m;
      m_ptr = (g + 1) % CHANNELS;
    end else if (m_valid != 0 && bus.res_ready === 1'b1) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic set_op(input int ch, input int a, input int b, input int m);
    bus.req_a[ch*WIDTH +: WIDTH] = WIDTH'(a);
    bus.req_b[ch*WIDTH +: WIDTH] = WIDTH'(b);
    bus.req_m[ch] = 1'(m);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    set_op(0, 3, 4, 0);
    bus.req_valid = 4'b0001;
    tick();
    n_checks++; if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL reset_pre_valid: got %0b expected 1", bus.res_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", bus.res_valid); end
    n_checks++; if (bus.res_data !== 4'd0 || bus.res_cout !== 1'b0) begin n_fail++; $display("FAIL reset_data: got %0d/%0b expected 0/0", bus.res_data, bus.res_cout); end
    n_checks++; if (bus.res_ch !== 2'd0 || bus.res_m !== 1'b0) begin n_fail++; $display("FAIL reset_ch_m: got %0d/%0b expected 0/0", bus.res_ch, bus.res_m); end
    n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready); end
    model_reset();
    @(negedge clk);
    bus.req_valid = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_single_channel();
    int av[3] = '{5, 9, 5};
    int bv[3] = '{9, 5, 9};
    int mv[3] = '{0, 1, 1};
    int dv[3] = '{14, 4, 12};
    int cv[3] = '{0, 0, 1};
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      bus.res_ready = 1'b1;
      set_op(1, av[t], bv[t], mv[t]);
      bus.req_valid = 4'b0010;
      #1;
      n_checks++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL ch1_ready[%0d]: got %b expected 0010", t, bus.req_ready); end
      tick();
      n_checks++; if (bus.res_data !== 4'(dv[t]) || bus.res_cout !== 1'(cv[t])) begin n_fail++; $display("FAIL ch1_result[%0d]: got %0d/%0b expected %0d/%0d", t, bus.res_data, bus.res_cout, dv[t], cv[t]); end
      n_checks++; if (bus.res_valid !== 1'b1 || bus.res_ch !== 2'd1 || bus.res_m !== 1'(mv[t])) begin n_fail++; $display("FAIL ch1_tag[%0d]: got v=%0b ch=%0d m=%0b expected 1/1/%0d", t, bus.res_valid, bus.res_ch, bus.res_m, mv[t]); end
    end
    @(negedge clk);
    bus.req_valid = '0;
  endtask

  task automatic test_overflow();
    @(negedge clk);
    set_op(0, 15, 1, 0);
    bus.req_valid = 4'b0001;
    tick();
    n_checks++; if (bus.res_data !== 4'd0 || bus.res_cout !== 1'b1 || bus.res_ch !== 2'd0) begin n_fail++; $display("FAIL overflow: got %0d/%0b ch=%0d expected 0/1 ch=0", bus.res_data, bus.res_cout, bus.res_ch); end
    @(negedge clk);
    bus.req_valid = '0;
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int c = 0; c < CHANNELS; c++) set_op(c, c + 1, c, c % 2);
    bus.req_valid = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      #1;
      n_checks++; if (bus.req_ready !== 4'(1 << order[t])) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b expected ch%0d", t, bus.req_ready, order[t]); end
      tick();
      n_checks++; if (bus.res_ch !== 2'(order[t]) || bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL rr_ch[%0d]: got %0d expected %0d", t, bus.res_ch, order[t]); end
      n_checks++; if (bus.res_data !== 4'(m_data) || bus.res_cout !== 1'(m_cout)) begin n_fail++; $display("FAIL rr_data[%0d]: got %0d/%0b expected %0d/%0d", t, bus.res_data, bus.res_cout, m_data, m_cout); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] d0;
    logic [CH_W-1:0]  c0;
    logic             co0;
    d0 = bus.res_data; c0 = bus.res_ch; co0 = bus.res_cout;
    bus.res_ready = 1'b0;
    bus.req_valid = 4'b1111;
    for (int t = 0; t < 3; t++) begin
      #1;
      n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b expected 0000", t, bus.req_ready); end
      tick();
      n_checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== d0 || bus.res_ch !== c0 || bus.res_cout !== co0) begin n_fail++; $display("FAIL bp_hold[%0d]: got v=%0b d=%0d ch=%0d expected v=1 d=%0d ch=%0d", t, bus.res_valid, bus.res_data, bus.res_ch, d0, c0); end
      @(negedge clk);
    end
    bus.res_ready = 1'b1;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 0010", bus.req_ready); end
    tick();
    n_checks++; if (bus.res_valid !== 1'b1 || bus.res_ch !== 2'd1) begin n_fail++; $display("FAIL bp_release_ch: got v=%0b ch=%0d expected 1/1", bus.res_valid, bus.res_ch); end
    @(negedge clk);
    bus.req_valid = '0;
  endtask

  task automatic test_ptr_wrap();
    do_reset();
    set_op(1, 1, 1, 0);
    bus.req_valid = 4'b0010;
    tick();
    @(negedge clk);
    set_op(0, 7, 2, 1);
    set_op(3, 8, 8, 0);
    bus.req_valid = 4'b1001;
    #1;
    n_checks++; if (bus.req_ready !== 4'b1000) begin n_fail++; $display("FAIL wrap_first: got %b expected 1000", bus.req_ready); end
    tick();
    n_checks++; if (bus.res_ch !== 2'd3 || bus.res_data !== 4'd0 || bus.res_cout !== 1'b1) begin n_fail++; $display("FAIL wrap_first_res: got ch=%0d d=%0d c=%0b expected 3/0/1", bus.res_ch, bus.res_data, bus.res_cout); end
    @(negedge clk);
    #1;
    n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL wrap_second: got %b expected 0001", bus.req_ready); end
    tick();
    n_checks++; if (bus.res_ch !== 2'd0 || bus.res_data !== 4'd5 || bus.res_cout !== 1'b0) begin n_fail++; $display("FAIL wrap_second_res: got ch=%0d d=%0d c=%0b expected 0/5/0", bus.res_ch, bus.res_data, bus.res_cout); end
    @(negedge clk);
    bus.req_valid = '0;
  endtask

  task automatic test_random();
    logic [CHANNELS-1:0] er;
    do_reset();
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      for (int c = 0; c < CHANNELS; c++) set_op(c, int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(1)));
      bus.req_valid = CHANNELS'($urandom);
      bus.res_ready = ($urandom_range(3) != 0);
      #1;
      er = exp_ready();
      n_checks++; if (bus.req_ready !== er) begin n_fail++; $display("FAIL rand_ready[%0d]: got %b expected %b", t, bus.req_ready, er); end
      tick();
      n_checks++; if (bus.res_valid !== 1'(m_valid) || bus.res_ch !== 2'(m_ch) || bus.res_m !== 1'(m_m)) begin n_fail++; $display("FAIL rand_tag[%0d]: got v=%0b ch=%0d m=%0b expected %0d/%0d/%0d", t, bus.res_valid, bus.res_ch, bus.res_m, m_valid, m_ch, m_m); end
      n_checks++; if (bus.res_data !== 4'(m_data) || bus.res_cout !== 1'(m_cout)) begin n_fail++; $display("FAIL rand_data[%0d]: got %0d/%0b expected %0d/%0d", t, bus.res_data, bus.res_cout, m_data, m_cout); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_m = '0;
    bus.res_ready = 1'b1;
    model_reset();
    test_reset();
    test_single_channel();
    test_overflow();
    test_round_robin();
    test_back_to_back();
    test_ptr_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
